// File: rtl/router_pkg.sv
// router_pkg: shared state encoding, LFSR taps and header builder for the router packet generator
package router_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    GAP     = 3'd4
  } state_t;
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;
  function automatic logic [15:0] build_hdr(input logic [15:0] len, input logic [15:0] addr, input int addr_w);
    return (len << addr_w) | addr;
  endfunction
endpackage

// File: rtl/router_lfsr16.sv
// router_lfsr16: 16-bit Fibonacci LFSR that steps on adv and reloads SEED on rst
//   clk, rst : clock, synchronous active-high reset
//   adv      : advance one step
//   q        : current LFSR state
module router_lfsr16 import router_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= SEED;
    else if (adv) q <= {q[14:0], q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D]};
endmodule

// File: rtl/router_pkt_gen.sv
// router_pkt_gen: header/payload/parity packet source for the router ingress port
//   start/dest_addr/payload_len : packet request, sampled while ready=1
//   busy                        : router back-pressure, holds the current beat
//   inj_parity_err              : (only with PKT_GEN_PARITY_ERR_EN) flip parity bit 0
//   ready/pkt_data/pkt_valid    : idle flag and outgoing byte stream
//   done/cfg_err/pkt_count      : completion pulse, rejected-start pulse, packet counter
module router_pkt_gen import router_pkg::*; #(
  parameter int          LEN_W      = 6,
  parameter int          ADDR_W     = 2,
  parameter int          DATA_W     = 8,
  parameter int          NUM_DEST   = 3,
  parameter int          GAP_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic              busy,
`ifdef PKT_GEN_PARITY_ERR_EN
  input  logic              inj_parity_err,
`endif
  output logic              ready,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_valid,
  output logic              done,
  output logic              cfg_err,
  output logic [15:0]       pkt_count
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEST_LIM = (ADDR_W+1)'(NUM_DEST);
  state_t state, state_n;
  logic [LEN_W-1:0] len_q, cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] parity_q, hdr, pay;
  logic [GW-1:0] gap_cnt;
  logic [15:0] lfsr_q;
  logic cfg_ok, take, acc, lfsr_adv, flip;
  assign cfg_ok = payload_len != '0 && {1'b0, dest_addr} < DEST_LIM;
  assign take = state == IDLE && start && cfg_ok;
  assign acc = !busy;
  assign hdr = DATA_W'(build_hdr(16'(len_q), 16'(addr_q), ADDR_W));
  assign pay = DATA_W'(lfsr_q);
  assign ready = state == IDLE;
  router_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .adv(lfsr_adv), .q(lfsr_q));
`ifdef PKT_GEN_PARITY_ERR_EN
  logic inj_q;
  always_ff @(posedge clk)
    if (rst) inj_q <= 1'b0;
    else if (take) inj_q <= inj_parity_err;
  assign flip = inj_q;
`else
  assign flip = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    pkt_valid = 1'b0;
    pkt_data = '0;
    lfsr_adv = 1'b0;
    case (state)
      IDLE: state_n = take ? HEADER : IDLE;
      HEADER: begin
        pkt_valid = 1'b1;
        pkt_data = hdr;
        state_n = acc ? PAYLOAD : HEADER;
      end
      PAYLOAD: begin
        pkt_valid = 1'b1;
        pkt_data = pay;
        lfsr_adv = acc;
        state_n = acc && cnt == len_q - LEN_W'(1) ? PARITY : PAYLOAD;
      end
      PARITY: begin
        pkt_data = parity_q ^ {{(DATA_W-1){1'b0}}, flip};
        state_n = acc ? (GAP_CYCLES == 0 ? IDLE : GAP) : PARITY;
      end
      GAP: state_n = gap_cnt == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      len_q <= '0;
      addr_q <= '0;
      parity_q <= '0;
      cnt <= '0;
      gap_cnt <= '0;
      done <= 1'b0;
      cfg_err <= 1'b0;
      pkt_count <= '0;
    end else begin
      done <= state == PARITY && acc;
      cfg_err <= state == IDLE && start && !cfg_ok;
      if (take) begin
        len_q <= payload_len;
        addr_q <= dest_addr;
        parity_q <= '0;
      end
      if (state == HEADER && acc) begin
        parity_q <= parity_q ^ hdr;
        cnt <= '0;
      end
      if (state == PAYLOAD && acc) begin
        parity_q <= parity_q ^ pay;
        cnt <= cnt + LEN_W'(1);
      end
      if (state == PARITY && acc) begin
        pkt_count <= pkt_count + 16'd1;
        gap_cnt <= '0;
      end
      if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
    end
endmodule

// File: tb/tb_router_pkt_gen.sv
// tb_router_pkt_gen: table-driven and scoreboard-checked bench for router_pkt_gen
module tb_router_pkt_gen;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int NDEST = 3;
  localparam int GAPC = 2;
  typedef struct packed {logic [7:0] d; logic v;} beat_t;
  typedef struct {logic [1:0] d; logic [5:0] l; bit err;} vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy = 1'b0, inj = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] payload_len = '0;
  logic ready, pkt_valid, done, cfg_err;
  logic [7:0] pkt_data;
  logic [15:0] pkt_count;
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, valid_cnt = 0;
  beat_t sb[$];
  logic [7:0] seen[$];
  int gaps[$];
  logic [15:0] m_lfsr = SEED;
  bit last_v = 0, gcount = 0;
  int grun = 0;
  int expc = 0;
  vec_t vt[8];

  router_pkt_gen dut (
    .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr),
    .payload_len(payload_len), .busy(busy),
`ifdef PKT_GEN_PARITY_ERR_EN
    .inj_parity_err(inj),
`endif
    .ready(ready), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .done(done), .cfg_err(cfg_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic push_pkt(input logic [1:0] d, input logic [5:0] l, input logic e);
    logic [7:0] h, par;
    h = {l, d};
    par = h;
    sb.push_back({h, 1'b1});
    for (int i = 0; i < int'(l); i++) begin
      sb.push_back({m_lfsr[7:0], 1'b1});
      par ^= m_lfsr[7:0];
      m_lfsr = lfsr_next(m_lfsr);
    end
`ifdef PKT_GEN_PARITY_ERR_EN
    sb.push_back({par ^ {7'd0, e}, 1'b0});
`else
    sb.push_back({par, 1'b0});
    if (e) par = par;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; busy = 1'b0; inj = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete(); seen.delete(); gaps.delete();
    m_lfsr = SEED; last_v = 0; gcount = 0;
  endtask

  task automatic send(input logic [1:0] d, input logic [5:0] l, input logic e);
    int n = 0;
    while (!ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!ready) chk("send_ready_timeout", 32'(ready), 32'd1);
    start = 1'b1; dest_addr = d; payload_len = l; inj = e;
    if (l != 0 && int'(d) < NDEST) push_pkt(d, l, e);
    @(posedge clk); #1;
    start = 1'b0; inj = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 300) begin @(negedge clk); n++; end
    if (!ready) chk("wait_ready_timeout", 32'(ready), 32'd1);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (done) done_cnt++;
    if (cfg_err) err_cnt++;
    if (pkt_valid) valid_cnt++;
    if (!rst && !busy && sb.size() > 0 && (pkt_valid || (last_v && !sb[0].v))) begin
      e = sb.pop_front();
      chk("beat_data", 32'(pkt_data), 32'(e.d));
      chk("beat_valid", 32'(pkt_valid), 32'(e.v));
      seen.push_back(pkt_data);
      last_v = e.v;
      if (!e.v) begin gcount = 1; grun = 0; end
    end else begin
      if (!rst && pkt_valid && sb.size() == 0) chk("unexpected_beat", 32'(pkt_valid), 32'd0);
      if (gcount) begin
        if (ready) begin gaps.push_back(grun); gcount = 0; end
        else if (!pkt_valid) grun++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, e0, v0;
    vt[0] = '{2'd0, 6'd2, 1'b0};
    vt[1] = '{2'd1, 6'd4, 1'b0};
    vt[2] = '{2'd3, 6'd5, 1'b1};
    vt[3] = '{2'd2, 6'd1, 1'b0};
    vt[4] = '{2'd1, 6'd0, 1'b1};
    vt[5] = '{2'd2, 6'd63, 1'b0};
    vt[6] = '{2'd3, 6'd0, 1'b1};
    vt[7] = '{2'd0, 6'd7, 1'b0};

    do_reset();
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(pkt_valid), 32'd0);
    chk("rst_data", 32'(pkt_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);

    d0 = done_cnt;
    send(2'd0, 6'd2, 1'b0);
    wait_ready();
    chk("s1_beats", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("s1_hdr", 32'(seen[0]), 32'h08);
      chk("s1_p0", 32'(seen[1]), 32'hE1);
      chk("s1_p1", 32'(seen[2]), 32'hC3);
      chk("s1_par", 32'(seen[3]), 32'h2A);
    end
    chk("s1_done", 32'(done_cnt - d0), 32'd1);
    chk("s1_count", 32'(pkt_count), 32'd1);

    do_reset();
    send(2'd0, 6'd2, 1'b0);
    @(posedge clk); #1; busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("busy_hold_data", 32'(pkt_data), 32'hE1);
      chk("busy_hold_valid", 32'(pkt_valid), 32'd1);
    end
    @(posedge clk); #1; busy = 1'b0;
    @(negedge clk);
    chk("busy_hold_data", 32'(pkt_data), 32'hE1);
    wait_ready();
    chk("busy_beats", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("busy_p1", 32'(seen[2]), 32'hC3);
      chk("busy_par", 32'(seen[3]), 32'h2A);
    end

    do_reset();
    send(2'd0, 6'd6, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    sb.delete(); seen.delete(); m_lfsr = SEED; last_v = 0; gcount = 0;
    @(negedge clk);
    chk("midrst_valid", 32'(pkt_valid), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_count", 32'(pkt_count), 32'd0);
    send(2'd1, 6'd3, 1'b0);
    wait_ready();
    if (seen.size() > 1) chk("midrst_first_payload", 32'(seen[1]), 32'hE1);
    else chk("midrst_beats", 32'(seen.size()), 32'd5);

    do_reset();
    expc = 0;
    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt; e0 = err_cnt; v0 = valid_cnt;
      send(vt[i].d, vt[i].l, 1'b0);
      @(negedge clk);
      chk("vec_cfg_err_pulse", 32'(cfg_err), 32'(vt[i].err));
      chk("vec_ready_after_start", 32'(ready), 32'(vt[i].err));
      @(negedge clk);
      wait_ready();
      if (!vt[i].err) expc++;
      chk("vec_cfg_err_count", 32'(err_cnt - e0), 32'(vt[i].err));
      chk("vec_done_count", 32'(done_cnt - d0), 32'(!vt[i].err));
      chk("vec_valid_beats", 32'(valid_cnt - v0), vt[i].err ? 32'd0 : 32'(vt[i].l) + 32'd1);
      chk("vec_pkt_count", 32'(pkt_count), 32'(expc));
      chk("vec_sb_empty", 32'(sb.size()), 32'd0);
    end

    do_reset();
    begin
      logic [1:0] bd[3];
      logic [5:0] bl[3];
      int idx = 0, n = 0;
      bd[0] = 2'd0; bd[1] = 2'd1; bd[2] = 2'd2;
      bl[0] = 6'd2; bl[1] = 6'd4; bl[2] = 6'd6;
      start = 1'b1; dest_addr = bd[0]; payload_len = bl[0];
      push_pkt(bd[0], bl[0], 1'b0);
      while (idx < 3 && n < 500) begin
        @(negedge clk); n++;
        if (ready) begin
          @(posedge clk); #1;
          idx++;
          if (idx < 3) begin
            dest_addr = bd[idx]; payload_len = bl[idx];
            push_pkt(bd[idx], bl[idx], 1'b0);
          end else start = 1'b0;
        end
      end
      start = 1'b0;
      chk("b2b_started", 32'(idx), 32'd3);
      wait_ready();
      @(negedge clk);
      chk("b2b_count", 32'(pkt_count), 32'd3);
      chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
      chk("b2b_gaps", 32'(gaps.size()), 32'd3);
      foreach (gaps[k]) chk("b2b_gap_len", 32'(gaps[k]), 32'(GAPC));
    end

`ifdef PKT_GEN_PARITY_ERR_EN
    do_reset();
    send(2'd0, 6'd2, 1'b1);
    wait_ready();
    if (seen.size() == 4) chk("inj_par", 32'(seen[3]), 32'h2B);
    else chk("inj_beats", 32'(seen.size()), 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
